qspi_flash_reader: RTL and testbench
====================================

// Module: qspi_flash_reader
// PURPOSE
//  SPI-mode serial flash read initiator; the counterpart of qspi_flash_buffer_mock.
//  Takes one 32-bit word-read request and drives cs/sclk/si with a READ (0x03) command
//  and a 24-bit address. Shifts 32 data bits in from so and returns a little-endian word.
//  Sits between the basic_soc instruction-fetch / flash AXI bridge and the flash pins.
// PARAMETERS
//  SCLK_HALF     1  clk cycles per sclk phase (low phase and high phase each); must be >= 1
//  CS_HIGH_GAP   2  min clk cycles cs stays high between transfers (deselect time); >= 1
// PORTS
//  clk          in   1   core clock
//  rst_n        in   1   asynchronous reset, active low
//  req_valid    in   1   read request valid
//  req_ready    out  1   request accepted when req_valid && req_ready at posedge clk
//  req_addr     in   24  flash byte address; bits [1:0] ignored (forced to 0)
//  resp_valid   out  1   read data valid; held until resp_ready
//  resp_ready   in   1   consumer accepts resp_data
//  resp_data    out  32  word read; first byte received -> [7:0], fourth -> [31:24]
//  cs           out  1   chip select, active low
//  sclk         out  1   serial clock, idles low (SPI mode 0)
//  capture_clk  out  1   copy of sclk for board-level capture alignment
//  si           out  1   serial data to flash, MSB first per byte
//  so           in   1   serial data from flash
//  wp           out  1   write protect, constant 1 (inactive)
//  hold         out  1   hold, constant 1 (inactive)
// BEHAVIOUR
//  Reset (async, immediate): state IDLE; cs=1, sclk=0, capture_clk=0, si=0, resp_valid=0,
//   resp_data=0, req_ready=0 until first clk after release, then 1; wp=hold=1 always.
//  States: IDLE -> SHIFT -> RESP -> GAP -> IDLE.
//  IDLE: req_ready=1. On accept: latch {req_addr[23:2],2'b00}; load 32-bit tx shift
//   {8'h03, addr}; clear bit counter; go SHIFT. req_ready=0 in all other states.
//  SHIFT: 64 bit slots (8 cmd + 24 addr + 32 data); cs=0 throughout.
//   - Each slot: SCLK_HALF cycles sclk=0, then SCLK_HALF cycles sclk=1.
//   - si is updated only at slot start (sclk low) and holds through the high phase.
//   - During data slots 32..63, si=0.
//   - In data slots, so is sampled on the clk edge ending the high phase (sclk 1->0).
//   - Bytes assemble MSB first; byte k lands in resp_data[8k+7:8k].
//   - First cycle after accept: cs=0, sclk=0, si=1'b0 (bit7 of 0x03).
//   - After the high phase of slot 63: go RESP.
//  RESP: cs=1, sclk=0, resp_valid=1, resp_data stable. On resp_ready: resp_valid=0, go GAP.
//   Accept-to-resp_valid latency = 1 + 128*SCLK_HALF cycles (129 for SCLK_HALF=1).
//  GAP: cs=1 for CS_HIGH_GAP cycles total, counted from the cycle cs rose.
//   Cycles already spent in RESP count toward the gap. Then IDLE.
//   If the gap is already met when RESP is accepted, go straight to IDLE.
//  Simultaneous events:
//   - req_valid during RESP/GAP is ignored (not accepted), no loss; requester holds it.
//   - resp_ready without resp_valid has no effect.
//  Reset mid-transfer: cs returns high asynchronously; partial data is discarded and no
//   response is issued.
//  capture_clk == sclk every cycle.
// TESTING
//  1 Mock holds bytes 13 05 C0 30 at 0x000; read 0x000 -> resp_data=32'h30C00513.
//    si carries 0x03,00,00,00 MSB first; resp_valid at accept+129 (SCLK_HALF=1).
//  2 Read req_addr=24'h00000E -> address on si is 0x00000C; data = word at 0x0C.
//  3 Back-to-back reads 0x0 then 0x4, req_valid held high.
//    cs high >= CS_HIGH_GAP cycles between them; both words correct.
//  4 Hold resp_ready=0 for 20 cycles -> resp_valid and resp_data stable, cs=1,
//    req_ready=0; release -> single handshake.
//  5 Assert rst_n=0 at slot 40 -> cs=1 and sclk=0 same timestep, no resp_valid.
//    A new read after release returns correct data.
//  6 SCLK_HALF=3: sclk period 6 clk, latency 385 cycles; wp=hold=1 in all tests.

Source files
------------

// File: rtl/qspi_flash_reader.sv
// SPI-mode (mode 0) serial flash word reader.
// Sends READ (0x03) followed by a word-aligned 24-bit address, then clocks in
// 32 data bits. The four bytes are returned little-endian: the first byte
// received lands in resp_data[7:0].
module qspi_flash_reader #(
    parameter int SCLK_HALF   = 1,
    parameter int CS_HIGH_GAP = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [23:0] req_addr,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        cs,
    output logic        sclk,
    output logic        capture_clk,
    output logic        si,
    input  logic        so,
    output logic        wp,
    output logic        hold
);
    localparam logic [15:0] HALF_LAST = 16'(SCLK_HALF - 1);
    localparam logic [15:0] GAP_MIN   = 16'(CS_HIGH_GAP);

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_RESP, ST_GAP} state_t;
    state_t state, state_nx;

    // tx_sr holds the not-yet-sent bits below the one currently on si
    logic [30:0] tx_sr;
    // rx_sr collects data bits; the last bit is merged straight from so
    logic [30:0] rx_sr;
    logic [5:0]  slot;
    logic [15:0] ph_cnt;
    logic [15:0] gap_cnt;
    logic        high_half;
    logic        half_end;
    logic        slot_end;
    logic        unused_ok;

    // Bytes arrive MSB-first in order; reverse byte order for a little-endian word
    function automatic logic [31:0] byte_swap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    assign half_end    = (ph_cnt == HALF_LAST);
    assign slot_end    = half_end && high_half;
    assign capture_clk = sclk;
    assign wp          = 1'b1;
    assign hold        = 1'b1;
    // Address bits [1:0] are deliberately dropped (word aligned reads)
    assign unused_ok   = &{1'b0, req_addr[1:0]};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    // Next-state logic; the cs-high gap includes cycles already spent in RESP
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (req_valid && req_ready) state_nx = ST_SHIFT;
            ST_SHIFT: if (slot_end && (slot == 6'd63)) state_nx = ST_RESP;
            ST_RESP:  if (resp_ready) state_nx = (gap_cnt >= GAP_MIN) ? ST_IDLE : ST_GAP;
            ST_GAP:   if (gap_cnt >= GAP_MIN) state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // Serial engine, response register and cs-high gap counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready  <= 1'b0;
            cs         <= 1'b1;
            sclk       <= 1'b0;
            si         <= 1'b0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            tx_sr      <= '0;
            rx_sr      <= '0;
            slot       <= '0;
            ph_cnt     <= '0;
            high_half  <= 1'b0;
            gap_cnt    <= '0;
        end else begin
            req_ready <= (state_nx == ST_IDLE);
            case (state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        // Bit 31 of the command word (0) goes out first
                        tx_sr     <= {7'h03, req_addr[23:2], 2'b00};
                        si        <= 1'b0;
                        cs        <= 1'b0;
                        sclk      <= 1'b0;
                        slot      <= '0;
                        ph_cnt    <= '0;
                        high_half <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (!half_end) begin
                        ph_cnt <= ph_cnt + 16'd1;
                    end else begin
                        ph_cnt <= '0;
                        if (!high_half) begin
                            high_half <= 1'b1;
                            sclk      <= 1'b1;
                        end else begin
                            // End of slot: sample so, then present the next si bit
                            high_half <= 1'b0;
                            sclk      <= 1'b0;
                            if (slot[5]) rx_sr <= {rx_sr[29:0], so};
                            if (slot == 6'd63) begin
                                cs         <= 1'b1;
                                resp_valid <= 1'b1;
                                resp_data  <= byte_swap({rx_sr, so});
                                gap_cnt    <= 16'd1;
                            end else begin
                                slot  <= slot + 6'd1;
                                tx_sr <= {tx_sr[29:0], 1'b0};
                                si    <= (slot < 6'd31) ? tx_sr[30] : 1'b0;
                            end
                        end
                    end
                end
                ST_RESP, ST_GAP: begin
                    if (gap_cnt < GAP_MIN) gap_cnt <= gap_cnt + 16'd1;
                    if ((state == ST_RESP) && resp_ready) resp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_qspi_flash_reader.sv
// Bench for qspi_flash_reader: a behavioural flash on the pins, a cycle-level
// reference of the serial waveform and handshakes, directed and random reads.
module tb_qspi_flash_reader;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        resp_ready = 1'b0;
    logic [23:0] req_addr = '0;
    logic        so = 1'b0;
    logic        sel = 1'b0;   // 0: SCLK_HALF=1 instance, 1: SCLK_HALF=3 instance

    logic        rr1, rv1, cs1, sclk1, cap1, si1, wp1, hold1;
    logic        rr3, rv3, cs3, sclk3, cap3, si3, wp3, hold3;
    logic [31:0] rd1, rd3;

    logic        a_rr, a_rv, a_cs, a_sclk, a_cap, a_si;
    logic [31:0] a_rd;
    assign a_rr   = sel ? rr3   : rr1;
    assign a_rv   = sel ? rv3   : rv1;
    assign a_cs   = sel ? cs3   : cs1;
    assign a_sclk = sel ? sclk3 : sclk1;
    assign a_cap  = sel ? cap3  : cap1;
    assign a_si   = sel ? si3   : si1;
    assign a_rd   = sel ? rd3   : rd1;

    always #5 clk = ~clk;

    qspi_flash_reader #(.SCLK_HALF(1), .CS_HIGH_GAP(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid & ~sel), .req_ready(rr1),
        .req_addr(req_addr), .resp_valid(rv1), .resp_ready(resp_ready), .resp_data(rd1),
        .cs(cs1), .sclk(sclk1), .capture_clk(cap1), .si(si1), .so(so), .wp(wp1), .hold(hold1));

    qspi_flash_reader #(.SCLK_HALF(3), .CS_HIGH_GAP(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid & sel), .req_ready(rr3),
        .req_addr(req_addr), .resp_valid(rv3), .resp_ready(resp_ready), .resp_data(rd3),
        .cs(cs3), .sclk(sclk3), .capture_clk(cap3), .si(si3), .so(so), .wp(wp3), .hold(hold3));

    int nchk = 0;
    int nfail = 0;
    int n_resp = 0;
    logic [7:0]  mem [0:255];
    logic [31:0] mock_cmd = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string nm);
        nchk++;
        nfail++;
        $display("FAIL %s: wait bound expired at %0t", nm, $time);
    endtask

    // Behavioural flash: latch 32 command/address bits on sclk rise, then
    // present data bits MSB-first, changing them after each sclk fall.
    initial begin : flash_mock
        int bitn;
        int j;
        logic [31:0] cmd;
        logic [7:0]  bt;
        forever begin
            @(negedge a_cs);
            bitn = 0;
            cmd  = '0;
            while (!a_cs) begin
                @(posedge a_sclk or posedge a_cs);
                if (a_cs) break;
                if (bitn < 32) cmd = {cmd[30:0], a_si};
                @(negedge a_sclk or posedge a_cs);
                if (a_cs) break;
                bitn++;
                if (bitn == 32) mock_cmd = cmd;
                if (bitn >= 32 && bitn < 64) begin
                    j  = bitn - 32;
                    bt = mem[8'(cmd[7:0] + 8'(j / 8))];
                    so = bt[7 - (j % 8)];
                end
            end
            so = 1'b0;
        end
    end

    // Reference: derive every output of the selected instance from the
    // transfer's position (cycles since accept) and cs-high history.
    logic [31:0] exp_cmd = '0, exp_word = '0, last_data = '0;
    bit xfer = 0, pend = 0, first_rel = 0, prev_sel = 0;
    int n = 0, hi = 1000, hh, gg, slot_i, ph_i;
    logic [23:0] aa;
    logic [7:0]  b0;

    always @(negedge clk) begin
        hh = sel ? 3 : 1;
        gg = sel ? 3 : 2;
        chk("wp_hold", {wp1, hold1, wp3, hold3}, 32'hF);
        chk("capture_clk", a_cap, a_sclk);
        if (sel != prev_sel) hi = 1000;
        prev_sel = sel;
        if (!rst_n) begin
            chk("rst_cs", a_cs, 1);
            chk("rst_sclk", a_sclk, 0);
            chk("rst_si", a_si, 0);
            chk("rst_resp_valid", a_rv, 0);
            chk("rst_resp_data", a_rd, 0);
            chk("rst_req_ready", a_rr, 0);
            xfer = 0; pend = 0; hi = 1000; first_rel = 1;
        end else begin
            hi = a_cs ? hi + 1 : 0;
            if (xfer) begin
                n++;
                if (n <= 128 * hh) begin
                    slot_i = (n - 1) / (2 * hh);
                    ph_i   = (n - 1) % (2 * hh);
                    chk("shift_cs", a_cs, 0);
                    chk("shift_sclk", a_sclk, (ph_i >= hh) ? 1 : 0);
                    chk("shift_si", a_si, (slot_i < 32) ? exp_cmd[31 - slot_i] : 1'b0);
                    chk("shift_resp_valid", a_rv, 0);
                    chk("shift_req_ready", a_rr, 0);
                end else begin
                    xfer = 0;
                    pend = 1;
                    chk("flash_saw_cmd", mock_cmd, exp_cmd);
                end
            end
            if (pend) begin
                chk("resp_valid", a_rv, 1);
                chk("resp_data", a_rd, exp_word);
                chk("resp_cs", a_cs, 1);
                chk("resp_sclk", a_sclk, 0);
                chk("resp_req_ready", a_rr, 0);
                if (resp_ready) begin
                    pend = 0;
                    last_data = a_rd;
                    n_resp++;
                end
            end else if (!xfer) begin
                chk("idle_resp_valid", a_rv, 0);
                chk("idle_cs", a_cs, 1);
                chk("idle_sclk", a_sclk, 0);
                if (first_rel) chk("req_ready_after_rst", a_rr, 0);
                else           chk("idle_req_ready", a_rr, (hi > gg) ? 1 : 0);
                first_rel = 0;
                if (req_valid && a_rr) begin
                    chk("cs_gap_met", (hi >= gg) ? 1 : 0, 1);
                    aa       = {req_addr[23:2], 2'b00};
                    exp_cmd  = {8'h03, aa};
                    b0       = aa[7:0];
                    exp_word = {mem[b0 + 8'd3], mem[b0 + 8'd2], mem[b0 + 8'd1], mem[b0]};
                    xfer = 1;
                    n = 0;
                end
            end
        end
    end

    // One read: present request, wait for accept and response, stall resp_ready
    // for rdy_wait cycles, then complete one handshake. Starts/ends at posedge+1.
    task automatic do_read(input logic [23:0] a, input int rdy_wait, input bit keep,
                           input logic [23:0] nxt, output int lat, output logic [31:0] data);
        int t;
        req_addr   = a;
        req_valid  = 1'b1;
        resp_ready = 1'b0;
        lat  = 0;
        data = '0;
        t = 0;
        while (a_rr !== 1'b1 && t < 2000) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 2000) begin fail_now("accept_timeout"); return; end
        @(posedge clk); #1;
        if (keep) req_addr = nxt;
        else      req_valid = 1'b0;
        lat = 1;
        while (a_rv !== 1'b1 && lat < 1000) begin
            @(posedge clk); #1;
            lat++;
        end
        if (lat >= 1000) begin fail_now("resp_timeout"); return; end
        data = a_rd;
        repeat (rdy_wait) begin @(posedge clk); #1; end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk("single_handshake", a_rv, 0);
    endtask

    initial begin : driver
        int lat, nreads, t;
        logic [31:0] d;
        logic [23:0] a_cur, a_nxt;
        bit kp;
        nreads = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h13; mem[1] = 8'h05; mem[2] = 8'hC0; mem[3] = 8'h30;
        mem[4] = 8'h11; mem[5] = 8'h22; mem[6] = 8'h33; mem[7] = 8'h44;
        mem[12] = 8'hDE; mem[13] = 8'hAD; mem[14] = 8'hBE; mem[15] = 8'hEF;

        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;

        // Word at 0x000, latency pinned to 129
        do_read(24'h000000, 0, 0, 24'h0, lat, d); nreads++;
        chk("t1_lat", lat, 129);
        chk("t1_data", d, 32'h30C00513);
        chk("t1_cmd", mock_cmd, 32'h03000000);

        // Low address bits dropped
        do_read(24'h00000E, 0, 0, 24'h0, lat, d); nreads++;
        chk("t2_cmd", mock_cmd, 32'h0300000C);
        chk("t2_data", d, 32'hEFBEADDE);

        // Back-to-back with req_valid held
        do_read(24'h000000, 0, 1, 24'h000004, lat, d); nreads++;
        chk("t3_data0", d, 32'h30C00513);
        do_read(24'h000004, 0, 0, 24'h0, lat, d); nreads++;
        chk("t3_data1", d, 32'h44332211);

        // Consumer stall for 20 cycles
        do_read(24'h00000C, 20, 0, 24'h0, lat, d); nreads++;
        chk("t4_data", last_data, 32'hEFBEADDE);

        // Reset in the high phase of slot 40
        req_addr  = 24'h000010;
        req_valid = 1'b1;
        t = 0;
        while (a_rr !== 1'b1 && t < 2000) begin @(posedge clk); #1; t++; end
        if (t >= 2000) fail_now("t5_accept_timeout");
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (81) @(posedge clk);
        #2;
        chk("t5_pre_rst_cs", a_cs, 0);
        chk("t5_pre_rst_sclk", a_sclk, 1);
        rst_n = 1'b0;
        #1;
        chk("t5_async_cs", a_cs, 1);
        chk("t5_async_sclk", a_sclk, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        do_read(24'h000000, 0, 0, 24'h0, lat, d); nreads++;
        chk("t5_after_rst_data", d, 32'h30C00513);

        // Random reads on the SCLK_HALF=1 instance
        a_cur = 24'($urandom);
        for (int i = 0; i < 12; i++) begin
            a_nxt = 24'($urandom);
            kp = (i == 11) ? 1'b0 : 1'($urandom_range(0, 1));
            do_read(a_cur, $urandom_range(0, 4), kp, a_nxt, lat, d); nreads++;
            a_cur = a_nxt;
        end

        // SCLK_HALF=3 instance
        @(posedge clk); #1;
        sel = 1'b1;
        @(posedge clk); #1;
        do_read(24'h000000, 0, 0, 24'h0, lat, d); nreads++;
        chk("t6_lat", lat, 385);
        chk("t6_data", d, 32'h30C00513);
        a_cur = 24'($urandom);
        for (int i = 0; i < 4; i++) begin
            a_nxt = 24'($urandom);
            kp = (i == 3) ? 1'b0 : 1'($urandom_range(0, 1));
            do_read(a_cur, $urandom_range(0, 3), kp, a_nxt, lat, d); nreads++;
            a_cur = a_nxt;
        end

        repeat (5) @(posedge clk);
        chk("resp_count", n_resp, nreads);
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
